// File: rtl/gam_pkg.sv
// Shared types and address arithmetic for the Gamma subset parameter fetch block.
package gam_pkg;

    typedef enum logic [1:0] {
        ST_CAPTURE,
        ST_IDLE,
        ST_FETCH,
        ST_RESP
    } state_t;

    // Byte address of field 0 of a subset record; record 0 of the BRAM is a frame header.
    function automatic logic [63:0] rec_byte_addr(
        input logic [63:0] idx,
        input logic [63:0] words_per_rec,
        input logic [63:0] first_field
    );
        return ((idx + 64'd1) * words_per_rec + first_field) << 2;
    endfunction

endpackage

// File: rtl/gam_subset_table.sv
// Per-subset base address / pixel count register file: two write ports, one combinational read port.
// Out-of-range write indices are ignored here and flagged by the parent; out-of-range reads return 0.
module gam_subset_table #(
    parameter int MAX_SUBSETS = 14,
    parameter int DATA_W      = 32,
    parameter int IDX_W       = $clog2(MAX_SUBSETS)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              base_wr_en,
    input  logic [IDX_W-1:0]  base_wr_idx,
    input  logic [DATA_W-1:0] base_wr_dat,
    input  logic              cnt_wr_en,
    input  logic [IDX_W-1:0]  cnt_wr_idx,
    input  logic [DATA_W-1:0] int_wr_dat,
    input  logic [DATA_W-1:0] fp_wr_dat,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic [DATA_W-1:0] rd_base,
    output logic [DATA_W-1:0] rd_int,
    output logic [DATA_W-1:0] rd_fp
);

    localparam logic [IDX_W:0] MAX_IDX = (IDX_W + 1)'(MAX_SUBSETS);

    logic [DATA_W-1:0] base_mem [MAX_SUBSETS];
    logic [DATA_W-1:0] int_mem  [MAX_SUBSETS];
    logic [DATA_W-1:0] fp_mem   [MAX_SUBSETS];

    logic base_ok, cnt_ok, rd_ok;

    assign base_ok = {1'b0, base_wr_idx} < MAX_IDX;
    assign cnt_ok  = {1'b0, cnt_wr_idx}  < MAX_IDX;
    assign rd_ok   = {1'b0, rd_idx}      < MAX_IDX;

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < MAX_SUBSETS; i++) begin
                base_mem[i] <= '0;
                int_mem[i]  <= '0;
                fp_mem[i]   <= '0;
            end
        end else begin
            if (base_wr_en && base_ok) begin
                base_mem[base_wr_idx] <= base_wr_dat;
            end
            if (cnt_wr_en && cnt_ok) begin
                int_mem[cnt_wr_idx] <= int_wr_dat;
                fp_mem[cnt_wr_idx]  <= fp_wr_dat;
            end
        end
    end

    assign rd_base = rd_ok ? base_mem[rd_idx] : '0;
    assign rd_int  = rd_ok ? int_mem[rd_idx]  : '0;
    assign rd_fp   = rd_ok ? fp_mem[rd_idx]   : '0;

endmodule

// File: rtl/gam_subset_param_fetch.sv
// Returns a subset's table entry plus NUM_FIELDS parameter-BRAM words; out_valid NUM_FIELDS*RD_LATENCY+1 edges after accept (1 on error).
// One request in flight: req_ready low from accept until the response handshake completes.
module gam_subset_param_fetch
    import gam_pkg::*;
#(
    parameter int MAX_SUBSETS      = 14,
    parameter int DATA_W           = 32,
    parameter int ADDR_W           = 32,
    parameter int RD_LATENCY       = 3,
    parameter int WORDS_PER_SUBSET = 5,
    parameter int FIRST_FIELD      = 3,
    parameter int NUM_FIELDS       = 2,
    parameter int IDX_W            = $clog2(MAX_SUBSETS)
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         base_wr_en,
    input  logic [IDX_W-1:0]             base_wr_idx,
    input  logic [DATA_W-1:0]            base_address,
    input  logic                         cnt_wr_en,
    input  logic [IDX_W-1:0]             cnt_wr_idx,
    input  logic [DATA_W-1:0]            num_pxl_int_in,
    input  logic [DATA_W-1:0]            num_pxl_fp_in,
    input  logic [IDX_W:0]               num_subsets,
    input  logic                         capture_done,
    input  logic                         parameters_done,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic [IDX_W-1:0]             req_subset,
    output logic                         param_en,
    output logic [3:0]                   param_we,
    output logic [ADDR_W-1:0]            param_addr,
    input  logic [DATA_W-1:0]            param_dout,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [DATA_W-1:0]            out_base_addr,
    output logic [DATA_W-1:0]            out_num_pxl_int,
    output logic [DATA_W-1:0]            out_num_pxl_fp,
    output logic [NUM_FIELDS*DATA_W-1:0] out_fields,
    output logic                         out_error,
    output logic                         cap_overflow
);

    localparam int CW = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
    localparam int KW = (NUM_FIELDS > 1) ? $clog2(NUM_FIELDS) : 1;
    localparam logic [IDX_W:0] MAX_IDX = (IDX_W + 1)'(MAX_SUBSETS);

    state_t            state, state_nxt;
    logic [DATA_W-1:0] tbl_base, tbl_int, tbl_fp;
    logic [CW-1:0]     wait_cnt;
    logic [KW-1:0]     fld_k;
    logic              accept, in_range, wait_done, last_field, wr_drop;
    logic [ADDR_W-1:0] start_addr;

    gam_subset_table #(
        .MAX_SUBSETS (MAX_SUBSETS),
        .DATA_W      (DATA_W),
        .IDX_W       (IDX_W)
    ) u_table (
        .clock       (clock),
        .reset       (reset),
        .base_wr_en  (base_wr_en),
        .base_wr_idx (base_wr_idx),
        .base_wr_dat (base_address),
        .cnt_wr_en   (cnt_wr_en),
        .cnt_wr_idx  (cnt_wr_idx),
        .int_wr_dat  (num_pxl_int_in),
        .fp_wr_dat   (num_pxl_fp_in),
        .rd_idx      (req_subset),
        .rd_base     (tbl_base),
        .rd_int      (tbl_int),
        .rd_fp       (tbl_fp)
    );

    assign accept     = req_valid && req_ready;
    assign in_range   = {1'b0, req_subset} < num_subsets;
    assign wait_done  = wait_cnt == CW'(RD_LATENCY - 1);
    assign last_field = fld_k == KW'(NUM_FIELDS - 1);
    assign wr_drop    = (base_wr_en && ({1'b0, base_wr_idx} >= MAX_IDX)) ||
                        (cnt_wr_en  && ({1'b0, cnt_wr_idx}  >= MAX_IDX));
    assign start_addr = ADDR_W'(rec_byte_addr(64'(req_subset), 64'(WORDS_PER_SUBSET),
                                              64'(FIRST_FIELD)));
    assign param_we   = 4'b0000;

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ST_CAPTURE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        req_ready = 1'b0;
        case (state)
            ST_CAPTURE: begin
                if (capture_done && parameters_done) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_nxt = in_range ? ST_FETCH : ST_RESP;
                end
            end
            ST_FETCH: begin
                if (wait_done && last_field) begin
                    state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                if (out_valid && out_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_CAPTURE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            param_en        <= 1'b0;
            param_addr      <= '0;
            wait_cnt        <= '0;
            fld_k           <= '0;
            out_valid       <= 1'b0;
            out_base_addr   <= '0;
            out_num_pxl_int <= '0;
            out_num_pxl_fp  <= '0;
            out_fields      <= '0;
            out_error       <= 1'b0;
            cap_overflow    <= 1'b0;
        end else begin
            cap_overflow <= cap_overflow | wr_drop;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        // Table is sampled before this edge's writes land.
                        out_base_addr   <= in_range ? tbl_base : '0;
                        out_num_pxl_int <= in_range ? tbl_int  : '0;
                        out_num_pxl_fp  <= in_range ? tbl_fp   : '0;
                        out_fields      <= '0;
                        out_error       <= !in_range;
                        wait_cnt        <= '0;
                        fld_k           <= '0;
                        if (in_range) begin
                            param_en   <= 1'b1;
                            param_addr <= start_addr;
                        end
                    end
                end
                ST_FETCH: begin
                    if (wait_done) begin
                        wait_cnt <= '0;
                        out_fields[int'(fld_k)*DATA_W +: DATA_W] <= param_dout;
                        if (last_field) begin
                            param_en <= 1'b0;
                        end else begin
                            param_addr <= param_addr + ADDR_W'(4);
                            fld_k      <= fld_k + KW'(1);
                        end
                    end else begin
                        wait_cnt <= wait_cnt + CW'(1);
                    end
                end
                ST_RESP: begin
                    // out_valid rises one edge after entering RESP.
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_gam_subset_param_fetch.sv
// Directed bench for gam_subset_param_fetch: spec-level model with per-cycle compare, plus literal checks.
module tb_gam_subset_param_fetch;

    localparam int MS = 14, DW = 32, AW = 32, RL = 3, WPS = 5, FF = 3, NF = 2;
    localparam int IW = 4;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              base_wr_en = 0, cnt_wr_en = 0;
    logic [IW-1:0]     base_wr_idx = '0, cnt_wr_idx = '0, req_subset = '0;
    logic [DW-1:0]     base_address = '0, num_pxl_int_in = '0, num_pxl_fp_in = '0;
    logic [IW:0]       num_subsets = 5'd4;
    logic              capture_done = 0, parameters_done = 0, req_valid = 0, out_ready = 0;
    logic              req_ready, param_en, out_valid, out_error, cap_overflow;
    logic [3:0]        param_we;
    logic [AW-1:0]     param_addr;
    logic [DW-1:0]     param_dout, out_base_addr, out_num_pxl_int, out_num_pxl_fp;
    logic [NF*DW-1:0]  out_fields;

    gam_subset_param_fetch dut (
        .clock(clock), .reset(reset),
        .base_wr_en(base_wr_en), .base_wr_idx(base_wr_idx), .base_address(base_address),
        .cnt_wr_en(cnt_wr_en), .cnt_wr_idx(cnt_wr_idx),
        .num_pxl_int_in(num_pxl_int_in), .num_pxl_fp_in(num_pxl_fp_in),
        .num_subsets(num_subsets), .capture_done(capture_done), .parameters_done(parameters_done),
        .req_valid(req_valid), .req_ready(req_ready), .req_subset(req_subset),
        .param_en(param_en), .param_we(param_we), .param_addr(param_addr), .param_dout(param_dout),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_base_addr(out_base_addr), .out_num_pxl_int(out_num_pxl_int),
        .out_num_pxl_fp(out_num_pxl_fp), .out_fields(out_fields),
        .out_error(out_error), .cap_overflow(cap_overflow)
    );

    always #5 clock = ~clock;

    int n_checks = 0, n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // BRAM: data for the address present at edge E is on param_dout after edge E+RL-1.
    logic [DW-1:0] mem [128];
    logic [DW-1:0] pipe [RL-1];
    always @(posedge clock) begin
        pipe[0] <= param_en ? mem[param_addr[8:2]] : 32'hDEAD_BEEF;
        for (int i = 1; i < RL - 1; i++) pipe[i] <= pipe[i-1];
    end
    assign param_dout = pipe[RL-2];

    // Behavioural model: table contents, phase flags and the single outstanding transaction.
    logic [DW-1:0] m_base [MS], m_int [MS], m_fp [MS];
    bit            capt = 1, trk = 0, t_in = 0, m_ovf = 0, chk_en = 0;
    int            c = 0;
    logic [31:0]   t_addr = 0, e_base = 0, e_int = 0, e_fp = 0;
    logic [63:0]   e_fields = 0;

    function automatic int lat_of(input bit inr);
        return inr ? NF * RL + 1 : 1;
    endfunction

    always @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < MS; i++) begin m_base[i] = 0; m_int[i] = 0; m_fp[i] = 0; end
            capt = 1; trk = 0; m_ovf = 0; chk_en = 1;
        end else begin
            if (trk) begin
                if (c >= lat_of(t_in) && out_ready) trk = 0;
                else c++;
            end else if (!capt && req_valid) begin
                int s, w;
                s = int'(req_subset);
                w = (s + 1) * WPS + FF;
                trk = 1; c = 0;
                t_in = s < int'(num_subsets);
                t_addr = 32'(w * 4);
                e_base = (t_in && s < MS) ? m_base[s] : 0;
                e_int  = (t_in && s < MS) ? m_int[s]  : 0;
                e_fp   = (t_in && s < MS) ? m_fp[s]   : 0;
                e_fields = t_in ? {mem[w+1], mem[w]} : 64'd0;
            end
            if (capt && capture_done && parameters_done) capt = 0;
            if (base_wr_en) begin
                if (int'(base_wr_idx) < MS) m_base[base_wr_idx] = base_address; else m_ovf = 1;
            end
            if (cnt_wr_en) begin
                if (int'(cnt_wr_idx) < MS) begin
                    m_int[cnt_wr_idx] = num_pxl_int_in;
                    m_fp[cnt_wr_idx]  = num_pxl_fp_in;
                end else m_ovf = 1;
            end
        end
    end

    always @(negedge clock) begin
        if (chk_en) begin
            bit ev, een;
            ev  = trk && c >= lat_of(t_in);
            een = trk && t_in && c < NF * RL;
            chk("req_ready", 64'(req_ready), 64'(!capt && !trk));
            chk("out_valid", 64'(out_valid), 64'(ev));
            chk("param_en", 64'(param_en), 64'(een));
            chk("param_we", 64'(param_we), 64'd0);
            chk("cap_overflow", 64'(cap_overflow), 64'(m_ovf));
            if (een) chk("param_addr", 64'(param_addr), 64'(t_addr + 32'(4 * (c / RL))));
            if (ev) begin
                chk("out_error", 64'(out_error), 64'(!t_in));
                chk("out_base_addr", 64'(out_base_addr), 64'(e_base));
                chk("out_num_pxl_int", 64'(out_num_pxl_int), 64'(e_int));
                chk("out_num_pxl_fp", 64'(out_num_pxl_fp), 64'(e_fp));
                chk("out_fields", out_fields, e_fields);
            end
        end
    end

    task automatic do_req(input logic [IW-1:0] s, input bit wr2, input int hold,
                          output int lat, output logic [31:0] a0, output logic [31:0] a1,
                          output logic [63:0] flds, output logic [31:0] base,
                          output bit en_seen, output logic err);
        @(negedge clock);
        req_valid = 1; req_subset = s;
        if (wr2) begin base_wr_en = 1; base_wr_idx = 4'd2; base_address = 32'h2222; end
        @(negedge clock);
        req_valid = 0; base_wr_en = 0;
        lat = -1; en_seen = 0; a0 = 0; a1 = 0;
        for (int n = 0; n < 40; n++) begin
            if (param_en) en_seen = 1;
            if (n == 0) a0 = param_addr;
            if (n == RL) a1 = param_addr;
            if (out_valid) begin lat = n; break; end
            @(negedge clock);
        end
        if (lat < 0) chk("resp_timeout", 64'(out_valid), 64'd1);
        flds = out_fields; base = out_base_addr; err = out_error;
        for (int h = 0; h < hold; h++) begin
            @(negedge clock);
            chk("hold_req_ready", 64'(req_ready), 64'd0);
            chk("hold_out_valid", 64'(out_valid), 64'd1);
            chk("hold_fields", out_fields, flds);
        end
        out_ready = 1;
        @(negedge clock);
        out_ready = 0;
        chk("release_out_valid", 64'(out_valid), 64'd0);
        chk("release_req_ready", 64'(req_ready), 64'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat; logic [31:0] a0, a1, base; logic [63:0] flds; bit en_seen; logic err;
        for (int i = 0; i < 128; i++) mem[i] = 32'hC000_0000 + 32'(i);
        mem[13] = 32'hAA; mem[14] = 32'hBB;

        repeat (3) @(negedge clock);
        reset = 0;
        @(negedge clock);
        chk("reset_req_ready", 64'(req_ready), 64'd0);
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_param_en", 64'(param_en), 64'd0);
        chk("reset_cap_overflow", 64'(cap_overflow), 64'd0);

        for (int i = 0; i < 4; i++) begin
            base_wr_en = 1; base_wr_idx = 4'(i); base_address = 32'h1000 + 32'(i);
            cnt_wr_en = 1; cnt_wr_idx = 4'(i); num_pxl_int_in = 32'(i); num_pxl_fp_in = 32'(2 * i);
            @(negedge clock);
        end
        base_wr_en = 0; cnt_wr_en = 0;
        chk("capture_req_ready", 64'(req_ready), 64'd0);
        capture_done = 1; parameters_done = 1;
        @(negedge clock);
        chk("idle_req_ready", 64'(req_ready), 64'd1);

        do_req(4'd1, 0, 10, lat, a0, a1, flds, base, en_seen, err);
        chk("s1_latency", 64'(lat), 64'd7);
        chk("s1_addr0", 64'(a0), 64'd52);
        chk("s1_addr1", 64'(a1), 64'd56);
        chk("s1_fields", flds, 64'h0000_00BB_0000_00AA);
        chk("s1_base", 64'(base), 64'h1001);

        do_req(4'd5, 0, 0, lat, a0, a1, flds, base, en_seen, err);
        chk("s5_latency", 64'(lat), 64'd1);
        chk("s5_error", 64'(err), 64'd1);
        chk("s5_param_en_seen", 64'(en_seen), 64'd0);
        chk("s5_base", 64'(base), 64'd0);

        do_req(4'd4, 0, 0, lat, a0, a1, flds, base, en_seen, err);
        chk("s4_error", 64'(err), 64'd1);
        do_req(4'd3, 0, 0, lat, a0, a1, flds, base, en_seen, err);
        chk("s3_error", 64'(err), 64'd0);
        chk("s3_fields", flds, {32'hC000_0018, 32'hC000_0017});

        do_req(4'd2, 1, 0, lat, a0, a1, flds, base, en_seen, err);
        chk("s2_old_base", 64'(base), 64'h1002);
        do_req(4'd2, 0, 0, lat, a0, a1, flds, base, en_seen, err);
        chk("s2_new_base", 64'(base), 64'h2222);

        cnt_wr_en = 1; cnt_wr_idx = 4'd13; num_pxl_int_in = 32'h55; num_pxl_fp_in = 32'h66;
        @(negedge clock);
        cnt_wr_en = 0;
        chk("idx13_no_overflow", 64'(cap_overflow), 64'd0);
        base_wr_en = 1; base_wr_idx = 4'd14; base_address = 32'hBAD;
        @(negedge clock);
        base_wr_en = 0;
        chk("idx14_overflow", 64'(cap_overflow), 64'd1);
        @(negedge clock);
        chk("overflow_sticky", 64'(cap_overflow), 64'd1);

        req_valid = 1; req_subset = 4'd0;
        @(negedge clock);
        req_valid = 0;
        repeat (2) @(negedge clock);
        chk("fetch_param_en", 64'(param_en), 64'd1);
        reset = 1; capture_done = 0; parameters_done = 0;
        @(negedge clock);
        chk("abort_param_en", 64'(param_en), 64'd0);
        chk("abort_out_valid", 64'(out_valid), 64'd0);
        chk("abort_base", 64'(out_base_addr), 64'd0);
        chk("abort_overflow", 64'(cap_overflow), 64'd0);
        reset = 0;
        repeat (2) @(negedge clock);
        chk("abort_capture_state", 64'(req_ready), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
